alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately.
REQ-003 in_valid  input  1  operation request valid.
REQ-004 in_ready  output  1  block can accept a request this cycle.
REQ-005 alu_ct  input  4  operation code from the ALU control decoder.
REQ-006 src_a  input  32  operand A.
REQ-007 src_b  input  32  operand B.
REQ-008 out_valid  output  1  result register holds an undelivered result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 result  output  32  operation result.
REQ-011 zero  output  1  result == 0.
REQ-012 overflow  output  1  signed overflow (ADD/SUB only).
REQ-013 illegal  output  1  alu_ct not a supported code.
REQ-014 busy  output  1  multi-cycle operation in progress.

Function
REQ-015 Codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1 or 0), 1100 NOR, 1000 MULU (low 32 bits of unsigned product).
REQ-016 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; operands and alu_ct captured at that edge.
REQ-017 in_ready SHALL be 1 only in state IDLE with out_valid=0 or out_ready=1 in the same cycle.
REQ-018 States SHALL be IDLE, MUL, HOLD; reset state IDLE.
REQ-019 IDLE, accept of single-cycle code -> HOLD; result, zero, overflow, illegal registered at the accept edge, out_valid=1 from the next cycle (latency 1).
REQ-020 IDLE, accept of MULU -> MUL; busy=1; shift-add over exactly 32 cycles; then -> HOLD with out_valid=1 (latency 33 from accept edge).
REQ-021 HOLD: result/flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 HOLD with out_ready=1: result delivered; with in_valid=1 in same cycle, new request accepted back-to-back (out_valid stays 1, new result); otherwise -> IDLE, out_valid=0.
REQ-023 ADD/SUB SHALL wrap modulo 2^32; overflow = sign of operands equal (B inverted for SUB) and sign of result differs.
REQ-024 MULU overflow SHALL be 0; upper 32 product bits discarded.
REQ-025 Unsupported code: result=0, zero=1, overflow=0, illegal=1, latency 1.
REQ-026 in_valid while in_ready=0 SHALL be ignored; requester holds request.
REQ-027 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 rst=0 SHALL force state IDLE, result=0, zero=0, overflow=0, illegal=0, out_valid=0, busy=0, multiplier counter/accumulator=0.
REQ-029 Reset during MUL or HOLD SHALL abort and discard the operation; no result delivered after release.
REQ-030 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-031 Macro ALU_EXEC_MUL_EN defined: MULU supported per REQ-020.
REQ-032 Macro undefined: MUL state and multiplier absent; 1000 treated as unsupported per REQ-025; busy tied 0.

Structure
REQ-033 Package alu_exec_pkg SHALL hold the alu_ct code constants, state enum, data width (32) and multiply iteration count (32).
REQ-034 Sub-module alu_mul_seq (start, operands, done, 32-bit product-low) SHALL implement the shift-add multiplier, instantiated only under ALU_EXEC_MUL_EN.

Verification
REQ-035 ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, overflow=1, zero=0, out_valid one cycle after accept.
REQ-036 SUB 5-5 then SLT 0xFFFFFFFF,0x00000001 back-to-back with out_ready=1 -> results 0 (zero=1) then 1, in consecutive cycles.
REQ-037 MULU 0x00010000*0x00010003 (MUL_EN) -> result 0x00030000, busy=1 for 32 cycles, out_valid at cycle 33, in_ready=0 meanwhile.
REQ-038 alu_ct=0101 -> result 0, illegal=1; same with 1000 built without ALU_EXEC_MUL_EN.
REQ-039 OR result with out_ready=0 for 10 cycles -> result stable, in_ready=0, new in_valid ignored; out_ready=1 -> delivered, back to IDLE.
REQ-040 rst=0 at MUL cycle 10 -> all outputs 0 immediately; after release no out_valid, in_ready=1.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute block: opcodes, FSM states,
// data width, multiply iteration count and the single-cycle datapath.
package alu_exec_pkg;

    localparam int DATA_W    = 32;
    localparam int MUL_ITERS = 32;
    localparam int MUL_CNT_W = $clog2(MUL_ITERS);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_MULU = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              overflow;
        logic              illegal;
    } alu_res_t;

    // MULU is never handled here; the top routes it to the multiplier when enabled.
    function automatic alu_res_t alu_single(input logic [3:0]        ct,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
        alu_res_t          r;
        logic [DATA_W-1:0] sum;
        logic [DATA_W-1:0] diff;
        r    = '0;
        sum  = a + b;
        diff = a - b;
        case (ct)
            ALU_AND: r.result = a & b;
            ALU_OR:  r.result = a | b;
            ALU_NOR: r.result = ~(a | b);
            ALU_ADD: begin
                r.result   = sum;
                r.overflow = (a[DATA_W-1] == b[DATA_W-1]) &&
                             (sum[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                r.result   = diff;
                r.overflow = (a[DATA_W-1] != b[DATA_W-1]) &&
                             (diff[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SLT: r.result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: r.illegal = 1'b1;
        endcase
        r.zero = (r.result == '0);
        return r;
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Request/response bundle between a requester (master) and the ALU execute block (slave).
interface alu_exec_if;
    import alu_exec_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        alu_ct;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              overflow;
    logic              illegal;
    logic              busy;

    modport master (
        output in_valid, alu_ct, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, overflow, illegal, busy
    );

    modport slave (
        input  in_valid, alu_ct, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, overflow, illegal, busy
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier returning the low product word; done is high during the
// final iteration cycle with product already reflecting that last step.
module alu_mul_seq
    import alu_exec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    logic [DATA_W-1:0]    mcand;
    logic [DATA_W-1:0]    mplier;
    logic [DATA_W-1:0]    acc;
    logic [DATA_W-1:0]    acc_next;
    logic [MUL_CNT_W-1:0] count;
    logic                 running;

    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign done     = running && (count == MUL_CNT_W'(MUL_ITERS - 1));
    assign product  = acc_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= op_a;
            mplier  <= op_b;
            acc     <= '0;
            count   <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage with valid/ready handshake on both sides.
// Define ALU_EXEC_MUL_EN to add the 32-cycle MULU path; otherwise MULU is illegal.
module alu_exec
    import alu_exec_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    alu_exec_if.slave  bus
);

    state_t            state;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              overflow_q;
    logic              illegal_q;
    logic              out_valid_q;
    logic              accept;
    alu_res_t          single;

    assign single = alu_single(bus.alu_ct, bus.src_a, bus.src_b);

    // Ready in IDLE, or in HOLD when the pending result leaves this same cycle.
    assign bus.in_ready = rst && (state != ST_MUL) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef ALU_EXEC_MUL_EN
    logic              busy_q;
    logic              mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    assign mul_start = accept && (bus.alu_ct == ALU_MULU);
    assign bus.busy  = busy_q;

    alu_mul_seq u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .op_a    (bus.src_a),
        .op_b    (bus.src_b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign bus.busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            busy_q      <= 1'b0;
`endif
        end else if (accept) begin
`ifdef ALU_EXEC_MUL_EN
            if (bus.alu_ct == ALU_MULU) begin
                state       <= ST_MUL;
                busy_q      <= 1'b1;
                out_valid_q <= 1'b0;
            end else
`endif
            begin
                state       <= ST_HOLD;
                result_q    <= single.result;
                zero_q      <= single.zero;
                overflow_q  <= single.overflow;
                illegal_q   <= single.illegal;
                out_valid_q <= 1'b1;
            end
        end else begin
            case (state)
`ifdef ALU_EXEC_MUL_EN
                ST_MUL: begin
                    if (mul_done) begin
                        state       <= ST_HOLD;
                        result_q    <= mul_product;
                        zero_q      <= (mul_product == '0);
                        overflow_q  <= 1'b0;
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
`endif
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: a reference model queues expected results at
// accept time and a monitor checks them as the DUT delivers each one.
module tb_alu_exec;
    import alu_exec_pkg::*;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        overflow;
        logic        illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t scoreboard[$];

    always #5 clk = ~clk;

    alu_exec_if bus ();

    alu_exec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic exp_t modelAlu(input logic [3:0] ct, input logic [31:0] a,
                                      input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e  = '0;
        case (ct)
            4'b0000: e.result = a & b;
            4'b0001: e.result = a | b;
            4'b1100: e.result = ~(a | b);
            4'b0010: begin
                wide       = sa + sb;
                e.result   = wide[31:0];
                e.overflow = (wide != longint'($signed(wide[31:0])));
            end
            4'b0110: begin
                wide       = sa - sb;
                e.result   = wide[31:0];
                e.overflow = (wide != longint'($signed(wide[31:0])));
            end
            4'b0111: e.result = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_EXEC_MUL_EN
            4'b1000: begin
                logic [63:0] prod;
                prod     = {32'd0, a} * {32'd0, b};
                e.result = prod[31:0];
            end
`endif
            default: e.illegal = 1'b1;
        endcase
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [3:0] ct, input logic [31:0] a,
                                 input logic [31:0] b, output int waited);
        bit taken;
        taken        = 1'b0;
        waited       = 0;
        bus.in_valid = 1'b1;
        bus.alu_ct   = ct;
        bus.src_a    = a;
        bus.src_b    = b;
        for (int i = 0; i < 100 && !taken; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                scoreboard.push_back(modelAlu(ct, a, b));
                taken = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        if (!taken) checkOutput("accept_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drainScoreboard();
        for (int i = 0; i < 100 && scoreboard.size() != 0; i++) waitCycles(1);
        checkOutput("drain", 32'(scoreboard.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            checkOutput("result_expected", 32'(scoreboard.size() != 0), 32'd1);
            if (scoreboard.size() != 0) begin
                exp_t e;
                e = scoreboard.pop_front();
                checkOutput("result",   bus.result,         e.result);
                checkOutput("zero",     32'(bus.zero),      32'(e.zero));
                checkOutput("overflow", 32'(bus.overflow),  32'(e.overflow));
                checkOutput("illegal",  32'(bus.illegal),   32'(e.illegal));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          w;
        exp_t        hold_exp;
        logic [3:0]  ops [6];
        logic        seen_valid;

        ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
        bus.in_valid  = 1'b0;
        bus.alu_ct    = 4'b0000;
        bus.src_a     = 32'd0;
        bus.src_b     = 32'd0;
        bus.out_ready = 1'b0;
        rst           = 1'b0;

        @(negedge clk);
        checkOutput("rst_result",    bus.result,          32'd0);
        checkOutput("rst_zero",      32'(bus.zero),       32'd0);
        checkOutput("rst_overflow",  32'(bus.overflow),   32'd0);
        checkOutput("rst_illegal",   32'(bus.illegal),    32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid),  32'd0);
        checkOutput("rst_busy",      32'(bus.busy),       32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Signed overflow on ADD with latency-1 delivery
        bus.out_ready = 1'b1;
        applyStimulus(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, w);
        @(negedge clk);
        checkOutput("add_latency", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;

        applyStimulus(ALU_SUB, 32'd5, 32'd5, w);
        applyStimulus(ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, w);
        checkOutput("slt_back_to_back_wait", 32'(w), 32'd0);

        applyStimulus(ALU_SUB, 32'h8000_0000, 32'h0000_0001, w);
        applyStimulus(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, w);
        applyStimulus(ALU_SLT, 32'h0000_0001, 32'hFFFF_FFFF, w);
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 3; j++) begin
                applyStimulus(ops[i], $urandom, $urandom, w);
            end
        end

        applyStimulus(4'b0101, 32'h1234_5678, 32'h9ABC_DEF0, w);
        @(negedge clk);
        checkOutput("illegal_latency", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;

`ifdef ALU_EXEC_MUL_EN
        begin
            int valid_cycle = 0;
            int busy_cycles = 0;
            int ready_seen  = 0;
            drainScoreboard();
            applyStimulus(ALU_MULU, 32'h0001_0000, 32'h0001_0003, w);
            for (int c = 1; c <= 40 && valid_cycle == 0; c++) begin
                @(negedge clk);
                if (bus.out_valid) begin
                    valid_cycle = c;
                end else begin
                    if (bus.busy) busy_cycles++;
                    if (bus.in_ready) ready_seen++;
                end
                @(posedge clk);
                #1;
            end
            checkOutput("mul_latency",     32'(valid_cycle), 32'd33);
            checkOutput("mul_busy_cycles", 32'(busy_cycles), 32'd32);
            checkOutput("mul_ready_low",   32'(ready_seen),  32'd0);
            applyStimulus(ALU_MULU, $urandom, $urandom, w);
            applyStimulus(ALU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
        end
`else
        applyStimulus(ALU_MULU, 32'd3, 32'd4, w);
`endif
        drainScoreboard();

        // Stalled consumer: result must hold while a second request is refused
        bus.out_ready = 1'b0;
        hold_exp = modelAlu(ALU_OR, 32'h0F0F_0000, 32'h0000_00F0);
        applyStimulus(ALU_OR, 32'h0F0F_0000, 32'h0000_00F0, w);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold_valid",    32'(bus.out_valid), 32'd1);
            checkOutput("hold_result",   bus.result,         hold_exp.result);
            checkOutput("hold_in_ready", 32'(bus.in_ready),  32'd0);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.alu_ct   = ALU_AND;
            bus.src_a    = $urandom;
            bus.src_b    = $urandom;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("idle_after_hold",  32'(bus.out_valid), 32'd0);
        checkOutput("ready_after_hold", 32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1;
        drainScoreboard();

`ifdef ALU_EXEC_MUL_EN
        applyStimulus(ALU_MULU, 32'd7, 32'd9, w);
        waitCycles(9);
`else
        bus.out_ready = 1'b0;
        applyStimulus(ALU_ADD, 32'd1, 32'd2, w);
        waitCycles(2);
`endif
        rst = 1'b0;
        #1;
        checkOutput("abort_result",    bus.result,          32'd0);
        checkOutput("abort_zero",      32'(bus.zero),       32'd0);
        checkOutput("abort_overflow",  32'(bus.overflow),   32'd0);
        checkOutput("abort_illegal",   32'(bus.illegal),    32'd0);
        checkOutput("abort_out_valid", 32'(bus.out_valid),  32'd0);
        checkOutput("abort_busy",      32'(bus.busy),       32'd0);
        checkOutput("abort_in_ready",  32'(bus.in_ready),   32'd0);
        scoreboard.delete();
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        seen_valid    = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_abort", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid = 1'b1;
        end
        checkOutput("no_result_after_abort", 32'(seen_valid), 32'd0);
        @(posedge clk);
        #1;

        applyStimulus(ALU_NOR, 32'hFFFF_0000, 32'h0000_FFFF, w);
        drainScoreboard();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
